// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master issuing SINGLE word transfers.
// Define AHB_TIMEOUT_EN to bound wait states to TIMEOUT_CYCLES consecutive stalls.
module ahb_lite_master #(
  parameter int HADDR_WIDTH    = 32,
  parameter int HDATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [HADDR_WIDTH-1:0] req_addr_i,
  input  logic [HDATA_WIDTH-1:0] req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [HDATA_WIDTH-1:0] rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   rsp_timeout_o,
  output logic [HADDR_WIDTH-1:0] haddr_o,
  output logic                   hwrite_o,
  output logic [1:0]             htrans_o,
  output logic [2:0]             hsize_o,
  output logic [2:0]             hburst_o,
  output logic [3:0]             hprot_o,
  output logic                   hmastlock_o,
  output logic [HDATA_WIDTH-1:0] hwdata_o,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
  input  logic [HDATA_WIDTH-1:0] hrdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR, S_RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                 state;
  logic                   ready_q;
  logic [HDATA_WIDTH-1:0] wdata_q;
  logic                   done;
  logic                   done_err;
  logic [HDATA_WIDTH-1:0] done_rdata;
  logic                   unused_hresp;

  assign hsize_o      = 3'b010;
  assign hburst_o     = 3'b000;
  assign hprot_o      = 4'b0011;
  assign hmastlock_o  = 1'b0;
  assign unused_hresp = hresp_i[1];

  // Ready is gated by rst_i so it drops in the very cycle reset is applied.
  assign req_ready_o = ready_q & ~rst_i;

`ifdef AHB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout_hit;
  logic             rsp_timeout_q;

  assign waiting     = !hready_i && (state == S_ADDR || state == S_DATA || state == S_ERR);
  assign timeout_hit = waiting && (wait_cnt == CNT_LAST);

  // Counter only survives cycles that stall without leaving the current state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (waiting && !timeout_hit && !(state == S_DATA && hresp_i[0]))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (done)
        rsp_timeout_q <= timeout_hit;
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Decide whether the transfer completes this cycle and with what response.
  always_comb begin
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    case (state)
      S_DATA: begin
        if (hready_i) begin
          done     = 1'b1;
          done_err = hresp_i[0];
          if (!hwrite_o && !hresp_i[0])
            done_rdata = hrdata_i;
        end
      end
      S_ERR: begin
        if (hready_i) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: ;
    endcase
`ifdef AHB_TIMEOUT_EN
    if (timeout_hit) begin
      done       = 1'b1;
      done_err   = 1'b1;
      done_rdata = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      ready_q     <= 1'b1;
      htrans_o    <= HTRANS_IDLE;
      haddr_o     <= '0;
      hwrite_o    <= 1'b0;
      hwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (done) begin
        state       <= S_RESP;
        htrans_o    <= HTRANS_IDLE;
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= done_err;
        rsp_rdata_o <= done_rdata;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (req_valid_i && ready_q) begin
              state    <= S_ADDR;
              ready_q  <= 1'b0;
              htrans_o <= HTRANS_NONSEQ;
              haddr_o  <= req_addr_i;
              hwrite_o <= req_write_i;
              wdata_q  <= req_wdata_i;
            end
          end
          S_ADDR: begin
            if (hready_i) begin
              state    <= S_DATA;
              htrans_o <= HTRANS_IDLE;
              hwdata_o <= wdata_q;
            end
          end
          S_DATA: begin
            // First cycle of a two-cycle ERROR response.
            if (hresp_i[0])
              state <= S_ERR;
          end
          S_ERR: ;
          S_RESP: begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master with a transaction-level timing/response model.
// Build with AHB_TIMEOUT_EN defined to also exercise the wait-state timeout.
`timescale 1ns/1ps
module tb_ahb_lite_master;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TOUT = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [AW-1:0] haddr_o;
  logic          hwrite_o, hmastlock_o;
  logic [1:0]    htrans_o;
  logic [2:0]    hsize_o, hburst_o;
  logic [3:0]    hprot_o;
  logic [DW-1:0] hwdata_o;
  logic          hready_i;
  logic [1:0]    hresp_i;
  logic [DW-1:0] hrdata_i;

  ahb_lite_master #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .haddr_o(haddr_o), .hwrite_o(hwrite_o), .htrans_o(htrans_o), .hsize_o(hsize_o),
    .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o),
    .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 clk_i = ~clk_i;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] last_rdata;
  logic          last_err, last_tout;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check("idle_ready", req_ready_o, 1);
      check("idle_rsp_valid", rsp_valid_o, 0);
      check("idle_htrans", htrans_o, 0);
      req_valid_i = 1'b0;
      hready_i    = 1'($urandom);
      hresp_i     = 2'($urandom);
    end
  endtask

  // kind: 0 OKAY, 1 two-cycle ERROR via ERR state, 2 ERROR completing with hready=1, 3 timeout
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int aw, input int dw, input int ew,
                        input int kind, input bit hold_valid);
    int            a_end, d_end, e_end, lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err, exp_tout;
    a_end     = aw + 1;
    d_end     = (kind == 3) ? a_end + TOUT : a_end + dw + 1;
    e_end     = (kind == 1) ? d_end + ew + 1 : d_end;
    lat       = e_end + 1;
    exp_err   = (kind != 0);
    exp_tout  = (kind == 3);
    exp_rdata = (kind == 0 && !wr) ? rdata : '0;

    @(negedge clk_i);
    check("pre_ready", req_ready_o, 1);
    check("pre_rsp_valid", rsp_valid_o, 0);
    check("hold_rdata", rsp_rdata_o, last_rdata);
    check("hold_err", rsp_err_o, last_err);
    check("hold_tout", rsp_timeout_o, last_tout);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    hready_i    = 1'b1;
    hresp_i     = 2'b00;

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk_i);
      check("rsp_valid", rsp_valid_o, (c == lat));
      if (c < lat) begin
        check("busy_ready", req_ready_o, 0);
        check("htrans", htrans_o, (c <= a_end) ? 2'b10 : 2'b00);
        check("haddr", haddr_o, addr);
        check("hwrite", hwrite_o, wr);
        if (c > a_end && c <= d_end) check("hwdata", hwdata_o, wdata);
      end else begin
        check("rsp_rdata", rsp_rdata_o, exp_rdata);
        check("rsp_err", rsp_err_o, exp_err);
        check("rsp_tout", rsp_timeout_o, exp_tout);
        check("resp_htrans", htrans_o, 0);
      end
      // Requests presented while busy must be ignored.
      req_valid_i = hold_valid ? 1'b1 : 1'($urandom);
      req_write_i = 1'($urandom);
      req_addr_i  = $urandom;
      req_wdata_i = $urandom;
      hrdata_i    = $urandom;
      hresp_i     = 2'b00;
      hready_i    = 1'b1;
      if (c <= a_end) begin
        hready_i = (c == a_end);
      end else if (c < d_end) begin
        hready_i = 1'b0;
      end else if (c == d_end) begin
        case (kind)
          0: begin hready_i = 1'b1; hrdata_i = rdata; end
          1: begin hready_i = 1'b0; hresp_i = 2'b11; end
          2: begin hready_i = 1'b1; hresp_i = 2'b11; end
          default: hready_i = 1'b0;
        endcase
      end else if (c <= e_end) begin
        hready_i = (c == e_end);
        hresp_i  = 2'b11;
      end else begin
        hready_i = 1'($urandom);
        hresp_i  = 2'($urandom);
      end
    end
    last_rdata = exp_rdata;
    last_err   = exp_err;
    last_tout  = exp_tout;
  endtask

  task automatic reset_in_data();
    @(negedge clk_i);
    check("rst_pre_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = $urandom;
    hready_i    = 1'b1;
    hresp_i     = 2'b00;
    @(negedge clk_i);
    check("rst_addr_htrans", htrans_o, 2'b10);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("rst_data_htrans", htrans_o, 2'b00);
    rst_i    = 1'b1;
    hrdata_i = $urandom;
    @(negedge clk_i);
    check("rst_htrans", htrans_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_haddr", haddr_o, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst_rsp_valid", rsp_valid_o, 0);
      check("post_rst_ready", req_ready_o, 1);
    end
    last_rdata = '0;
    last_err   = 1'b0;
    last_tout  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    hready_i    = 1'b1;
    hresp_i     = 2'b00;
    hrdata_i    = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_htrans", htrans_o, 0);
    check("reset_haddr", haddr_o, 0);
    check("reset_hwrite", hwrite_o, 0);
    check("reset_hwdata", hwdata_o, 0);
    check("reset_ready", req_ready_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_rdata", rsp_rdata_o, 0);
    check("reset_err", rsp_err_o, 0);
    check("reset_tout", rsp_timeout_o, 0);
    check("hsize", hsize_o, 3'b010);
    check("hburst", hburst_o, 3'b000);
    check("hprot", hprot_o, 4'b0011);
    check("hmastlock", hmastlock_o, 0);
    rst_i      = 1'b0;
    last_rdata = '0;
    last_err   = 1'b0;
    last_tout  = 1'b0;

    do_txn(1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 1'b0);
    do_txn(1'b0, 32'h4, 32'h0, 32'h12345678, 0, 2, 0, 0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 0, 0, 0, 1, 1'b0);
    do_txn(1'b1, 32'h14, 32'h55AA55AA, 32'h0, 1, 1, 0, 2, 1'b0);
    // Back-to-back with req_valid_i held high throughout.
    do_txn(1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, 0, 0, 0, 1'b1);
    do_txn(1'b1, 32'h24, 32'h01234567, 32'h0, 0, 0, 0, 0, 1'b1);
    idle_cycles(1);
    reset_in_data();

    for (int n = 0; n < 60; n++) begin
      do_txn(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
      idle_cycles($urandom_range(0, 2));
    end

`ifdef AHB_TIMEOUT_EN
    do_txn(1'b0, 32'h40, 32'h0, 32'h0, 0, 0, 0, 3, 1'b0);
    do_txn(1'b1, 32'h44, 32'h13572468, 32'h0, 2, 0, 0, 3, 1'b0);
    do_txn(1'b0, 32'h48, 32'h0, 32'h89ABCDEF, 0, 1, 0, 0, 1'b0);
`endif

    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter HADDR_WIDTH, default 32: AHB address width.
REQ-002 SHALL have parameter HDATA_WIDTH, default 32: AHB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: wait-state limit, used only with AHB_TIMEOUT_EN.
REQ-004 SHALL have one clock and one reset: synchronous, active-high reset.
REQ-005 SHALL have ports: clk_i  in  1  clock, all logic on rising edge.
REQ-006 SHALL have ports: rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have request ports: req_valid_i in 1; req_ready_o out 1; req_write_i in 1; req_addr_i in HADDR_WIDTH; req_wdata_i in HDATA_WIDTH.
REQ-008 SHALL have response ports: rsp_valid_o out 1; rsp_rdata_o out HDATA_WIDTH; rsp_err_o out 1; rsp_timeout_o out 1.
REQ-009 SHALL have AHB master outputs: haddr_o HADDR_WIDTH; hwrite_o 1; htrans_o 2; hsize_o 3; hburst_o 3; hprot_o 4; hmastlock_o 1; hwdata_o HDATA_WIDTH.
REQ-010 SHALL have AHB master inputs: hready_i 1 (bus HREADY); hresp_i 2 (error when bit0=1); hrdata_i HDATA_WIDTH.

Function
REQ-011 SHALL drive constant hsize_o=3'b010, hburst_o=3'b000 (SINGLE), hprot_o=4'b0011, hmastlock_o=0.
REQ-012 SHALL use FSM states IDLE, ADDR, DATA, ERR, RESP; one transfer outstanding at a time.
REQ-013 IDLE: htrans_o=IDLE (00), req_ready_o=1; on req_valid_i&req_ready_o capture write/addr/wdata and go to ADDR.
REQ-014 req_ready_o SHALL be 1 only in IDLE and not in reset.
REQ-015 ADDR: htrans_o=NONSEQ (10), haddr_o/hwrite_o = captured values; go to DATA on the first edge with hready_i=1, else hold all outputs.
REQ-016 DATA: htrans_o=IDLE; hwdata_o = captured wdata for the entire data phase; haddr_o/hwrite_o hold captured values.
REQ-017 DATA with hready_i=1 and hresp_i[0]=0: capture hrdata_i for reads (0 for writes), rsp_err=0, go to RESP.
REQ-018 DATA with hready_i=0 and hresp_i[0]=1: go to ERR (first cycle of the two-cycle error response).
REQ-019 DATA with hready_i=1 and hresp_i[0]=1: treat as a completed error and go to RESP with rsp_err=1.
REQ-020 ERR: htrans_o=IDLE; go to RESP with rsp_err=1 and rdata=0 on the first cycle with hready_i=1.
REQ-021 RESP: rsp_valid_o=1 for exactly one cycle with rsp_rdata_o/rsp_err_o/rsp_timeout_o valid, then return to IDLE; there is no response backpressure.
REQ-022 rsp_rdata_o, rsp_err_o and rsp_timeout_o SHALL hold their values until the next RESP.
REQ-023 Minimum latency from request accept to rsp_valid_o SHALL be 3 cycles (ADDR, DATA, RESP); minimum issue interval SHALL be 4 cycles.
REQ-024 Each wait-state cycle (hready_i=0) in ADDR, DATA or ERR SHALL add exactly one cycle to the latency.
REQ-025 req_valid_i asserted outside IDLE SHALL be ignored; the request is not captured.

Reset
REQ-026 While rst_i=1 SHALL force state IDLE with: htrans_o=00, haddr_o=0, hwrite_o=0, hwdata_o=0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0, and the timeout counter cleared.
REQ-027 Reset in any state SHALL abort the transfer with no response issued; the first post-reset cycle SHALL be IDLE with req_ready_o=1.

Configuration
REQ-028 Macro AHB_TIMEOUT_EN defined: a counter SHALL count consecutive hready_i=0 cycles in ADDR, DATA and ERR, clearing on hready_i=1 or on a state change.
REQ-029 With AHB_TIMEOUT_EN, the count reaching TIMEOUT_CYCLES SHALL force RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, and htrans_o=IDLE.
REQ-030 Macro AHB_TIMEOUT_EN undefined: there SHALL be no counter logic, rsp_timeout_o SHALL be tied 0, and wait states SHALL be unbounded.

Verification
REQ-031 Write addr=0x8, wdata=0xDEADBEEF, hready_i=1 always -> NONSEQ at 0x8 for 1 cycle; hwdata_o=0xDEADBEEF next cycle; rsp_valid_o 3 cycles after accept with rsp_err_o=0.
REQ-032 Read addr=0x4 with 2 wait states in DATA, hrdata_i=0x12345678 when hready_i=1 -> rsp_rdata_o=0x12345678 5 cycles after accept.
REQ-033 Read with hresp_i=2'b11 and hready_i=0 for 1 cycle, then hready_i=1 -> passes through ERR; rsp_err_o=1, rsp_rdata_o=0.
REQ-034 Back-to-back requests with req_valid_i held high -> second accept exactly 4 cycles after the first; req_ready_o=0 in between.
REQ-035 rst_i pulsed while in DATA -> next cycle htrans_o=00, rsp_valid_o never asserted, req_ready_o=1 after release.
REQ-036 With AHB_TIMEOUT_EN and TIMEOUT_CYCLES=4, hready_i held 0 in DATA -> rsp_valid_o with rsp_err_o=1 and rsp_timeout_o=1 after 4 stalled cycles.
